pcs_pattern_gen_chk: RTL

//  Synthesisable fixed-pattern generator and self-aligning checker for 64b/66b PCS data blocks.

---
 rtl/pcs_pattern_gen_chk_pkg.sv | 34 +++
 rtl/pcs_pattern_chk.sv | 157 +++++++++++++++
 rtl/pcs_pattern_gen_chk.sv | 93 +++++++++
 3 files changed

// File: rtl/pcs_pattern_gen_chk_pkg.sv
// Shared constants for the PCS pattern generator/checker: sync header, checker
// state encodings, default pattern table and small index helpers.
// No logic, no latency, no flow control.
package pcs_pattern_gen_chk_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Entry 0 sits in the LSBs: 0=FF.., 1=00.., 2=55.., 3=AA.., 4=FE.., 5=07..
  localparam logic [6*64-1:0] DEF_PATTERNS = {
    64'h0707_0707_0707_0707,
    64'hFEFE_FEFE_FEFE_FEFE,
    64'hAAAA_AAAA_AAAA_AAAA,
    64'h5555_5555_5555_5555,
    64'h0000_0000_0000_0000,
    64'hFFFF_FFFF_FFFF_FFFF
  };

  // Out-of-table selects fall back to entry 0.
  function automatic logic [3:0] clamp_sel(input logic [3:0] sel, input int num);
    return (int'(sel) >= num) ? 4'd0 : sel;
  endfunction

  // Index of the block expected after entry idx.
  function automatic logic [3:0] next_idx(input logic [3:0] idx, input logic mode,
                                          input int num);
    if (mode) return idx;
    return (int'(idx) >= num - 1) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/pcs_pattern_chk.sv
// Self-aligning checker for returned 64b/66b data blocks: search, verify, lock, count errors.
// Latency: chk_lock/err_pulse/counters update on the edge after the block is sampled.
// Backpressure: none; acts only on rx_valid cycles, never stalls the source.
// Ports: clk/rst (sync, active high); cfg_* run configuration; err_clear clears counters;
//        rx_data/rx_hdr/rx_valid returned stream; chk_lock, err_pulse, err_count, block_count status.
module pcs_pattern_chk
  import pcs_pattern_gen_chk_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int HDR_WIDTH     = 2,
  parameter int NUM_PATTERNS  = 6,
  parameter logic [NUM_PATTERNS*DATA_WIDTH-1:0] PATTERNS = DEF_PATTERNS,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_COUNT  = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_enable,
  input  logic                     cfg_mode,
  input  logic [3:0]               cfg_pattern_sel,
  input  logic                     err_clear,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic [HDR_WIDTH-1:0]     rx_hdr,
  input  logic                     rx_valid,
  output logic                     chk_lock,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ERR_CNT_WIDTH-1:0] block_count
);

  logic [DATA_WIDTH-1:0] pat [16];
  for (genvar g = 0; g < 16; g++) begin : g_pat
    if (g < NUM_PATTERNS) begin : g_used
      assign pat[g] = PATTERNS[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_unused
      assign pat[g] = '0;
    end
  end

  logic [1:0]  state;
  logic [3:0]  exp_idx;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
  logic        mode_q;
  logic [3:0]  sel_q;

  logic [3:0]  sel_c;
  logic        hdr_ok;
  logic        exp_match;
  logic        hit;
  logic [3:0]  hit_idx;
  logic        cfg_changed;
  logic        blk_inc;
  logic        err_inc;

  assign sel_c       = clamp_sel(cfg_pattern_sel, NUM_PATTERNS);
  assign hdr_ok      = (rx_hdr == HDR_WIDTH'(SYNC_DATA));
  assign exp_match   = hdr_ok && (rx_data == pat[exp_idx]);
  // Any reconfiguration invalidates the current alignment.
  assign cfg_changed = !cfg_enable || (cfg_mode != mode_q) || (cfg_pattern_sel != sel_q);
  assign blk_inc     = !cfg_changed && rx_valid && (state == ST_LOCKED);
  assign err_inc     = blk_inc && !exp_match;

  // Search: descending scan so the lowest matching entry is left in hit_idx.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 4'd0;
    if (cfg_mode) begin
      hit     = hdr_ok && (rx_data == pat[sel_c]);
      hit_idx = sel_c;
    end else begin
      for (int i = NUM_PATTERNS - 1; i >= 0; i--) begin
        if (hdr_ok && (rx_data == pat[i[3:0]])) begin
          hit     = 1'b1;
          hit_idx = i[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEARCH;
      exp_idx   <= 4'd0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      mode_q    <= 1'b0;
      sel_q     <= 4'd0;
      chk_lock  <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      mode_q    <= cfg_mode;
      sel_q     <= cfg_pattern_sel;
      err_pulse <= 1'b0;
      chk_lock  <= (state == ST_LOCKED);
      if (cfg_changed) begin
        state    <= ST_SEARCH;
        good_cnt <= '0;
        bad_cnt  <= '0;
        chk_lock <= 1'b0;
      end else if (rx_valid) begin
        case (state)
          ST_SEARCH: begin
            if (hit) begin
              exp_idx  <= next_idx(hit_idx, cfg_mode, NUM_PATTERNS);
              good_cnt <= 16'd1;
              bad_cnt  <= '0;
              state    <= (LOCK_COUNT <= 1) ? ST_LOCKED : ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (exp_match) begin
              exp_idx  <= next_idx(exp_idx, cfg_mode, NUM_PATTERNS);
              good_cnt <= good_cnt + 16'd1;
              if (int'(good_cnt) + 1 >= LOCK_COUNT) state <= ST_LOCKED;
            end else begin
              good_cnt <= '0;
              state    <= ST_SEARCH;
            end
          end
          ST_LOCKED: begin
            // Expected index keeps advancing on errors so short bursts keep alignment.
            exp_idx <= next_idx(exp_idx, cfg_mode, NUM_PATTERNS);
            if (exp_match) begin
              bad_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (int'(bad_cnt) + 1 >= UNLOCK_COUNT) begin
                bad_cnt  <= '0;
                good_cnt <= '0;
                state    <= ST_SEARCH;
              end else begin
                bad_cnt <= bad_cnt + 16'd1;
              end
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || err_clear) begin
      err_count   <= '0;
      block_count <= '0;
    end else begin
      if (err_inc && (err_count != '1))
        err_count <= err_count + ERR_CNT_WIDTH'(1);
      if (blk_inc && (block_count != '1))
        block_count <= block_count + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pcs_pattern_gen_chk.sv
// Fixed-pattern 64b/66b block generator plus self-aligning loopback checker.
// Latency: generator output registered, 1 cycle from cfg; checker per pcs_pattern_chk.
// Backpressure: none; tx_valid streams every enabled cycle, rx accepted whenever valid.
// Ports: clk/rst (sync, active high); cfg_enable/cfg_mode/cfg_pattern_sel; err_clear;
//        tx_data/tx_hdr/tx_valid generated stream; rx_* returned stream; chk_lock/err_* status.
module pcs_pattern_gen_chk
  import pcs_pattern_gen_chk_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int HDR_WIDTH     = 2,
  parameter int NUM_PATTERNS  = 6,
  parameter logic [NUM_PATTERNS*DATA_WIDTH-1:0] PATTERNS = DEF_PATTERNS,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_COUNT  = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_enable,
  input  logic                     cfg_mode,
  input  logic [3:0]               cfg_pattern_sel,
  input  logic                     err_clear,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic [HDR_WIDTH-1:0]     tx_hdr,
  output logic                     tx_valid,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic [HDR_WIDTH-1:0]     rx_hdr,
  input  logic                     rx_valid,
  output logic                     chk_lock,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ERR_CNT_WIDTH-1:0] block_count
);

  logic [DATA_WIDTH-1:0] pat [16];
  for (genvar g = 0; g < 16; g++) begin : g_pat
    if (g < NUM_PATTERNS) begin : g_used
      assign pat[g] = PATTERNS[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_unused
      assign pat[g] = '0;
    end
  end

  logic [3:0] idx;
  logic [3:0] sel_c;

  assign sel_c = clamp_sel(cfg_pattern_sel, NUM_PATTERNS);

  always_ff @(posedge clk) begin
    if (rst || !cfg_enable) begin
      idx      <= 4'd0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_hdr   <= '0;
    end else begin
      tx_valid <= 1'b1;
      tx_hdr   <= HDR_WIDTH'(SYNC_DATA);
      if (cfg_mode) begin
        // Use the select directly so a new sel shows up on the very next block.
        tx_data <= pat[sel_c];
        idx     <= sel_c;
      end else begin
        tx_data <= pat[idx];
        idx     <= next_idx(idx, 1'b0, NUM_PATTERNS);
      end
    end
  end

  pcs_pattern_chk #(
    .DATA_WIDTH   (DATA_WIDTH),
    .HDR_WIDTH    (HDR_WIDTH),
    .NUM_PATTERNS (NUM_PATTERNS),
    .PATTERNS     (PATTERNS),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT),
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_chk (
    .clk            (clk),
    .rst            (rst),
    .cfg_enable     (cfg_enable),
    .cfg_mode       (cfg_mode),
    .cfg_pattern_sel(cfg_pattern_sel),
    .err_clear      (err_clear),
    .rx_data        (rx_data),
    .rx_hdr         (rx_hdr),
    .rx_valid       (rx_valid),
    .chk_lock       (chk_lock),
    .err_pulse      (err_pulse),
    .err_count      (err_count),
    .block_count    (block_count)
  );

endmodule
